unsigned_seq_multiplier: RTL and testbench
==========================================

Name: unsigned_seq_multiplier

Overview:
- Sequential unsigned shift-add multiplier; it is the arithmetic counterpart of the team's shift-subtract divider.
- Contains its own control FSM, iteration counter and product datapath.
- Sits beside the divider in the ALU/MDU cluster and uses the same run/rdy level handshake.
- Computes a WIDTH x WIDTH -> 2*WIDTH product, one iteration per clock.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset asserted).
- run  input  1  level request; must stay high for the whole operation.
- multiplicand  input  WIDTH  operand A; sampled only on the load edge.
- multiplier  input  WIDTH  operand B; sampled only on the load edge.
- product  output  2*WIDTH  product register; valid only while rdy=1.
- busy  output  1  high while iterating (ITER state).
- rdy  output  1  result valid (DONE state).

Behaviour:
- Reset (rst low, asynchronous, any state):
  - state=IDLE, count=0, product=0, mcand register=0, busy=0, rdy=0.
  - Reset mid-operation aborts the operation; no partial result is kept.
- States: IDLE, ITER, DONE. Registered outputs: busy=1 only in ITER, rdy=1 only in DONE.
- IDLE:
  - On an edge with run=1 (load edge E0): mcand<=multiplicand, product<={WIDTH'b0, multiplier}, count<=0, go to ITER.
  - run=0: stay in IDLE; product holds its last value.
- ITER, edge with run=1, one iteration:
  - If product[0]=1: sum = {1'b0, product[2W-1:W]} + {1'b0, mcand}, which is WIDTH+1 bits.
  - Otherwise: sum = {1'b0, product[2W-1:W]}.
  - product <= {sum, product[W-1:1]}, i.e. shift right by 1 with the carry entering the MSB.
  - count <= count+1.
  - On the iteration where count=WIDTH-1, the update is applied and the state goes to DONE.
- ITER, edge with run=0: pause. State, count and product are all held; busy stays 1; the operation resumes when run returns high.
- DONE:
  - rdy=1; product holds the final value.
  - Stays in DONE while run=1.
  - On an edge with run=0: go to IDLE, rdy<=0; product is kept.
- Latency: load edge E0 plus WIDTH iteration edges E1..EW. rdy is high after edge EW, which is the 33rd rising edge for WIDTH=32 with no pauses.
- Back-to-back operations: run must be seen low for at least one edge (the DONE->IDLE edge) before the next load. A continuously high run never restarts the operation.
- Operand inputs are don't-care outside the load edge; changing them during ITER or DONE must not affect the result.
- Width rules: the carry from the upper-half add is never lost. The final product is exact for all operands; no overflow is possible.
- count is wide enough to hold WIDTH-1, i.e. clog2(WIDTH) bits.

Test Plan:
- Basic: rst low then high; run=1, A=3, B=5.
  - Required: busy=1 for 32 cycles; rdy=1 after the 33rd edge; product=64'h0000_0000_0000_000F.
  - Then run=0: rdy=0 after one edge, and product still reads 15.
- Max carry: A=B=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 with rdy=1.
- Zero and identity: A=0, B=32'h1234_5678 -> product=0. Then A=1, B=32'h8000_0000 -> product=64'h0000_0000_8000_0000. Operands are changed on every ITER cycle; the results must be unaffected.
- Pause: A=32'h0001_0000, B=32'h0001_0000; drop run for 5 cycles after the 10th ITER edge.
  - Required: busy stays 1 and count is frozen during the pause.
  - rdy rises 5 edges later than nominal; product=64'h0000_0001_0000_0000.
- Reset mid-op: assert rst low at ITER count=17, asynchronously (mid-cycle).
  - Required: product, busy and rdy go to 0 immediately, without waiting for a clock edge.
  - After release with run=1, A=7, B=6: product=42 after 33 edges.
- Restart rule: hold run=1 through DONE for 10 cycles.
  - Required: rdy stays 1, and no new load occurs even though the operand inputs change.
  - Lower run for one edge, then raise it: a new load occurs and busy=1.

Source files
------------

// File: rtl/unsigned_seq_multiplier.sv
// Sequential unsigned shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one iteration per clock.
// Uses the run/rdy level handshake shared with the shift-subtract divider.
module unsigned_seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 rdy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic [2*WIDTH-1:0]    product_q, product_d;

    logic [WIDTH:0]        addend;
    logic [WIDTH:0]        sum;
    logic                  last_iter;

    // One bit wider than an operand so the upper-half carry is never dropped.
    always_comb begin
        addend = product_q[0] ? {1'b0, mcand_q} : '0;
        sum    = {1'b0, product_q[2*WIDTH-1:WIDTH]} + addend;
    end

    assign last_iter = (count_q == CntLast);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; run low in StIter is a pause, not an abort.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StIter;
            end
            StIter: begin
                if (run && last_iter) state_d = StDone;
            end
            StDone: begin
                if (!run) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        busy = 1'b0;
        rdy  = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StIter:  busy = 1'b1;
            StDone:  rdy  = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        mcand_d   = mcand_q;
        product_d = product_q;
        count_d   = count_q;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    mcand_d   = multiplicand;
                    product_d = {{WIDTH{1'b0}}, multiplier};
                    count_d   = '0;
                end
            end
            StIter: begin
                if (run) begin
                    product_d = {sum, product_q[WIDTH-1:1]};
                    count_d   = count_q + 1'b1;
                end
            end
            StDone:  ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q   <= '0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            mcand_q   <= mcand_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_unsigned_seq_multiplier.sv
// Scoreboard bench for unsigned_seq_multiplier: directed operands with hand-computed products,
// checked by a monitor on every rising rdy.
module tb_unsigned_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] product;
    logic        busy;
    logic        rdy;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    bit done_flag = 0;

    unsigned_seq_multiplier #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .rdy          (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop the oldest expected product on each rising rdy.
    initial begin
        logic rdy_prev;
        logic [63:0] exp;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_rdy", 64'd1, 64'd0);
                end else begin
                    exp = sb.pop_front();
                    check("sb_product", product, exp);
                end
            end
            rdy_prev = rdy;
        end
    end

    // Load, iterate (optionally pausing / scrambling operands) and wait for rdy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                          input int pause_after, input bit scramble);
        int  n;
        bit  paused;
        bit  busy_ok;
        n       = 0;
        paused  = 0;
        busy_ok = 1;
        sb.push_back(exp);
        multiplicand = a;
        multiplier   = b;
        run          = 1'b1;
        @(posedge clk);
        #1;
        while (rdy !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (scramble) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            if (pause_after > 0 && n == pause_after && !paused) begin
                run = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (busy !== 1'b1 || rdy !== 1'b0) busy_ok = 0;
                end
                run    = 1'b1;
                paused = 1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("busy_while_iter", {63'd0, busy_ok}, 64'd1);
        check("iter_edges", 64'(n), (pause_after > 0) ? 64'd37 : 64'd32);
        check("busy_low_in_done", {63'd0, busy}, 64'd0);
    endtask

    // Drop run for one edge; rdy must fall and the product must be kept.
    task automatic finish_op(input logic [63:0] exp);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_low_after_done", {63'd0, rdy}, 64'd0);
        check("product_kept", product, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        run          = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_product", product, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_rdy", {63'd0, rdy}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, -1, 0);
        finish_op(64'd15);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1, 0);
        finish_op(64'hFFFF_FFFE_0000_0001);

        run_op(32'd0, 32'h1234_5678, 64'd0, -1, 1);
        finish_op(64'd0);
        run_op(32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, -1, 1);
        finish_op(64'h0000_0000_8000_0000);

        run_op(32'hDEAD_BEEF, 32'd2, 64'h0000_0001_BD5B_7DDE, -1, 0);
        finish_op(64'h0000_0001_BD5B_7DDE);

        run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 10, 0);
        finish_op(64'h0000_0001_0000_0000);

        // Asynchronous reset in the middle of the 18th iteration cycle.
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        run          = 1'b1;
        @(posedge clk);
        repeat (17) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_product", product, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_rdy", {63'd0, rdy}, 64'd0);
        #2;
        rst = 1'b1;
        run_op(32'd7, 32'd6, 64'd42, -1, 0);

        // run held high through DONE must not restart the operation.
        for (int i = 0; i < 10; i++) begin
            multiplicand = $urandom;
            multiplier   = $urandom;
            @(posedge clk);
            #1;
            check("hold_rdy", {63'd0, rdy}, 64'd1);
            check("hold_product", product, 64'd42);
        end
        finish_op(64'd42);
        run_op(32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340, -1, 0);
        finish_op(64'h0000_0000_0001_2340);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
